// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the unified-memory fill/store arbiter.
package wisc_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WRITE = 2'd1,
        ARB_FILL  = 2'd2
    } arb_state_t;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_IDX_BITS   = 3;
    localparam int BLK_OFF_BITS    = 4;
    localparam logic FILL_SEL_I    = 1'b0;
    localparam logic FILL_SEL_D    = 1'b1;

endpackage

// File: rtl/fill_word_counter.sv
// Word-index counter for block fills: synchronous clear wins over enable; last flags the final index.
module fill_word_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign last = &cnt;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the shared pipelined memory among D-cache stores, D-cache fills and I-cache fills,
// issuing one read per block word and steering returned words into the selected cache.
module mem_fill_arbiter
    import wisc_mem_pkg::*;
#(
    parameter int AW              = 16,
    parameter int DW              = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LAT         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_miss,
    input  logic [AW-1:0] i_miss_addr,
    input  logic          d_miss,
    input  logic [AW-1:0] d_miss_addr,
    input  logic          d_wr_req,
    input  logic [AW-1:0] d_wr_addr,
    input  logic [DW-1:0] d_wr_data,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid,
    output logic          fill_we,
    output logic          fill_sel,
    output logic [2:0]    fill_word,
    output logic [DW-1:0] fill_data,
    output logic          fill_tag_we,
    output logic          i_done,
    output logic          d_done,
    output logic          wr_ack,
    output logic          busy
);

    if (WORDS_PER_BLOCK != (1 << WORD_IDX_BITS)) begin : g_blk_check
        $error("WORDS_PER_BLOCK must match the 3-bit word counters");
    end
    if (MEM_LAT < 1) begin : g_lat_check
        $error("MEM_LAT must be at least 1");
    end

    arb_state_t             state;
    logic [AW-1:0]          base;
    logic [AW-1:0]          grant_base;
    logic                   fill_grant;
    logic                   in_fill;
    logic [WORD_IDX_BITS-1:0] issue_cnt;
    logic [WORD_IDX_BITS-1:0] issue_nxt;
    logic [WORD_IDX_BITS-1:0] ret_cnt;
    logic                   issue_last;
    logic                   ret_last;

    assign in_fill    = (state == ARB_FILL);
    assign fill_grant = (state == ARB_IDLE) && !d_wr_req && (d_miss || i_miss);
    assign grant_base = d_miss ? {d_miss_addr[AW-1:BLK_OFF_BITS], {BLK_OFF_BITS{1'b0}}}
                               : {i_miss_addr[AW-1:BLK_OFF_BITS], {BLK_OFF_BITS{1'b0}}};
    assign issue_nxt  = issue_cnt + 1'b1;

    fill_word_counter #(.W(WORD_IDX_BITS)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fill_grant),
        .en    (in_fill && mem_en),
        .cnt   (issue_cnt),
        .last  (issue_last)
    );

    fill_word_counter #(.W(WORD_IDX_BITS)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fill_grant),
        .en    (in_fill && mem_valid),
        .cnt   (ret_cnt),
        .last  (ret_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            base      <= '0;
            fill_sel  <= FILL_SEL_I;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_ack    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (d_wr_req) begin
                        state     <= ARB_WRITE;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= d_wr_addr;
                        mem_wdata <= d_wr_data;
                        wr_ack    <= 1'b1;
                    end else if (d_miss || i_miss) begin
                        state    <= ARB_FILL;
                        fill_sel <= d_miss ? FILL_SEL_D : FILL_SEL_I;
                        base     <= grant_base;
                        mem_en   <= 1'b1;
                        mem_wr   <= 1'b0;
                        mem_addr <= grant_base;
                    end
                end
                ARB_WRITE: begin
                    state     <= ARB_IDLE;
                    mem_en    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    wr_ack    <= 1'b0;
                end
                ARB_FILL: begin
                    // Reads stream one per cycle; returns are counted independently below.
                    if (mem_en) begin
                        if (issue_last) begin
                            mem_en   <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            mem_addr <= base | AW'({issue_nxt, 1'b0});
                        end
                    end
                    if (mem_valid && ret_last)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Returned words are written in the cycle they arrive; stale returns outside FILL are dropped.
    assign fill_we     = in_fill && mem_valid;
    assign fill_word   = fill_we ? ret_cnt : '0;
    assign fill_data   = fill_we ? mem_rdata : '0;
    assign fill_tag_we = fill_we && ret_last;
    assign i_done      = fill_tag_we && (fill_sel == FILL_SEL_I);
    assign d_done      = fill_tag_we && (fill_sel == FILL_SEL_D);
    assign busy        = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench: stimulus pushes expected memory accesses and fill writes; a monitor pops on each DUT event.
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr, mem_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        fill_we, fill_sel, fill_tag_we, i_done, d_done, wr_ack, busy;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        sel;
        logic [2:0]  word;
        logic [15:0] data;
        logic        tag;
        logic        idn;
        logic        ddn;
    } fill_exp_t;

    mem_exp_t  mem_q[$];
    fill_exp_t fill_q[$];

    mem_fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
        .fill_tag_we(fill_tag_we), .i_done(i_done), .d_done(d_done), .wr_ack(wr_ack), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Four-stage read pipe: a read issued in cycle n returns in cycle n+4; not reset, so
    // reads in flight across a reset still come back.
    logic [3:0]  pv = '0;
    logic [15:0] pd [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_en & ~mem_wr};
        pd[0] <= mem_word(mem_addr);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign mem_valid = pv[3];
    assign mem_rdata = pv[3] ? pd[3] : 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_fill(input logic sel, input logic [15:0] addr, input int c0,
                               input int n_mem, input int n_fill);
        logic [15:0] b;
        b = {addr[15:4], 4'h0};
        for (int k = 0; k < n_mem; k++)
            mem_q.push_back('{c0 + 1 + k, 1'b0, b | 16'(k * 2), 16'h0});
        for (int k = 0; k < n_fill; k++)
            fill_q.push_back('{c0 + 5 + k, sel, 3'(k), mem_word(b | 16'(k * 2)),
                               k == 7, (k == 7) && !sel, (k == 7) && sel});
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [15:0] d, input int c0);
        mem_q.push_back('{c0 + 1, 1'b1, a, d});
    endtask

    // Waits for a pulse (0 = i_done, 1 = d_done, 2 = wr_ack), then returns just after the next edge.
    task automatic wait_pulse(input int which, input string name);
        bit seen;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = (which == 0) ? i_done : (which == 1) ? d_done : wr_ack;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: pulse not seen within 40 cycles (cycle %0d)", name, cyc);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: every bus access and fill write must match the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_en", {16'h0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    chk("mem_cycle", cyc, e.cyc);
                    chk("mem_wr", mem_wr, e.wr);
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wdata", mem_wdata, e.wdata);
                    chk("wr_ack", wr_ack, e.wr);
                end
            end else begin
                chk("idle_bus", {mem_wr, wr_ack, mem_addr, mem_wdata}, 32'h0);
            end
            if (fill_we) begin
                if (fill_q.size() == 0) begin
                    chk("unexpected_fill_we", {13'h0, fill_word, fill_data}, 32'hFFFF_FFFF);
                end else begin
                    fill_exp_t f;
                    f = fill_q.pop_front();
                    chk("fill_cycle", cyc, f.cyc);
                    chk("fill_sel", fill_sel, f.sel);
                    chk("fill_word", fill_word, f.word);
                    chk("fill_data", fill_data, f.data);
                    chk("fill_done", {fill_tag_we, i_done, d_done}, {f.tag, f.idn, f.ddn});
                end
            end else begin
                chk("stray_pulse", {fill_tag_we, i_done, d_done}, 3'b000);
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, {mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel, fill_word,
                   fill_data, fill_tag_we, i_done, d_done, wr_ack, busy}, 0);
    endtask

    initial begin
        int c0;
        rst_n = 0; i_miss = 0; d_miss = 0; d_wr_req = 0;
        i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset_state");
        rst_n = 1;
        @(posedge clk); #1;

        // I fill, then a back-to-back I fill re-requested in the IDLE cycle.
        c0 = cyc;
        i_miss = 1; i_miss_addr = 16'h1236;
        expect_fill(1'b0, 16'h1236, c0, 8, 8);
        @(posedge clk); #1 chk("busy_fill", busy, 1'b1);
        wait_pulse(0, "i_done_1");
        chk("idle_cycle", cyc, c0 + 13);
        i_miss_addr = 16'h0100;
        expect_fill(1'b0, 16'h0100, cyc, 8, 8);
        wait_pulse(0, "i_done_2");
        i_miss = 0;
        repeat (2) @(posedge clk); #1;

        // Simultaneous misses: D wins, I follows when the D fill retires.
        c0 = cyc;
        i_miss = 1; i_miss_addr = 16'h0040;
        d_miss = 1; d_miss_addr = 16'h8008;
        expect_fill(1'b1, 16'h8008, c0, 8, 8);
        expect_fill(1'b0, 16'h0040, c0 + 13, 8, 8);
        wait_pulse(1, "d_done_pri");
        d_miss = 0;
        wait_pulse(0, "i_done_pri");
        i_miss = 0;
        repeat (2) @(posedge clk); #1;

        // Store beats a same-cycle D miss.
        c0 = cyc;
        d_wr_req = 1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;
        d_miss = 1; d_miss_addr = 16'h3456;
        expect_write(16'h2002, 16'hBEEF, c0);
        expect_fill(1'b1, 16'h3456, c0 + 2, 8, 8);
        wait_pulse(2, "wr_ack_1");
        d_wr_req = 0;
        wait_pulse(1, "d_done_st");
        d_miss = 0;
        repeat (2) @(posedge clk); #1;

        // Store raised mid I fill waits for the fill to retire.
        c0 = cyc;
        i_miss = 1; i_miss_addr = 16'h0A0E;
        expect_fill(1'b0, 16'h0A0E, c0, 8, 8);
        repeat (3) @(posedge clk); #1;
        d_wr_req = 1; d_wr_addr = 16'h4444; d_wr_data = 16'h1357;
        expect_write(16'h4444, 16'h1357, c0 + 13);
        wait_pulse(0, "i_done_st");
        i_miss = 0;
        wait_pulse(2, "wr_ack_2");
        d_wr_req = 0;
        repeat (2) @(posedge clk); #1;

        // Reset in cycle 7 of a fill: outputs clear at once, late returns are ignored.
        c0 = cyc;
        i_miss = 1; i_miss_addr = 16'h0C80;
        expect_fill(1'b0, 16'h0C80, c0, 6, 2);
        repeat (7) @(posedge clk); #1;
        rst_n = 0; i_miss = 0;
        #1 chk_all_zero("async_reset");
        repeat (2) @(posedge clk); #1;
        rst_n = 1;
        repeat (6) @(posedge clk); #1;
        chk("busy_end", busy, 1'b0);
        chk("mem_q_empty", mem_q.size(), 0);
        chk("fill_q_empty", fill_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
